mac_seq_ctrl: RTL and testbench

Sequencer for one fully-connected layer built around the shared `acc` accumulator. It walks every (neuron, input) pair and issues weight, activation and bias read addresses. It drives the accumulator's bias-seed select and output-capture enable, aligned to memory read latency, and writes each finished neuron sum to the output buffer. An optional argmax tracker reports the winning class index at layer end.

---
 rtl/mac_seq_ctrl_if.sv | 33 +++
 rtl/mac_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Bus between the FC-layer sequencer and its memories, accumulator and output buffer.
interface mac_seq_ctrl_if #(
  parameter int IN_AW  = 10,
  parameter int W_AW   = 13,
  parameter int OUT_AW = 4
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     mem_re;
  logic [IN_AW-1:0]         in_addr;
  logic [W_AW-1:0]          w_addr;
  logic [OUT_AW-1:0]        b_addr;
  logic                     sel;
  logic                     en;
  logic                     out_we;
  logic [OUT_AW-1:0]        out_addr;
  logic signed [21:0]       acc_dout;
  logic [OUT_AW-1:0]        class_id;
  logic                     class_valid;

  modport master (
    input  start, acc_dout,
    output busy, done, mem_re, in_addr, w_addr, b_addr, sel, en,
           out_we, out_addr, class_id, class_valid
  );

  modport slave (
    output start, acc_dout,
    input  busy, done, mem_re, in_addr, w_addr, b_addr, sel, en,
           out_we, out_addr, class_id, class_valid
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Fully-connected layer sequencer: walks (neuron, input) pairs, aligns acc seed/capture to read latency.
// Optional argmax tracker enabled by defining MAC_SEQ_ARGMAX_EN.
module mac_seq_ctrl #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 10,
  parameter int RD_LAT = 1,
  parameter int IN_AW  = 10,
  parameter int W_AW   = 13,
  parameter int OUT_AW = 4
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [IN_AW-1:0]  r_i;
  logic [OUT_AW-1:0] r_n;
  logic [W_AW-1:0]   r_w;
  logic              r_out_we;
  logic [OUT_AW-1:0] r_out_addr;

  logic w_issue, w_first, w_last_i, w_last_all, w_sel, w_en, w_final_we;

  assign w_issue    = (r_state == S_RUN);
  assign w_first    = (r_i == '0);
  assign w_last_i   = (r_i == IN_AW'(N_IN - 1));
  assign w_last_all = w_last_i && (r_n == OUT_AW'(N_OUT - 1));
  assign w_final_we = r_out_we && (r_out_addr == OUT_AW'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last_all) w_next = S_DRAIN;
      S_DRAIN: if (w_final_we) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counters freeze on the final pair so addresses hold through DRAIN/DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i <= '0;
      r_n <= '0;
      r_w <= '0;
    end else if ((r_state == S_IDLE && bus.start) || r_state == S_DONE) begin
      r_i <= '0;
      r_n <= '0;
      r_w <= '0;
    end else if (w_issue && !w_last_all) begin
      r_w <= r_w + 1'b1;
      if (w_last_i) begin
        r_i <= '0;
        r_n <= r_n + 1'b1;
      end else begin
        r_i <= r_i + 1'b1;
      end
    end
  end

  // Tag pipeline: stage 0 is the issue cycle, stage RD_LAT lines up with read data.
  wire [RD_LAT:0]             vld_pipe;
  wire [RD_LAT:0]             first_pipe;
  wire [RD_LAT:0]             last_pipe;
  wire [RD_LAT:0][OUT_AW-1:0] n_pipe;

  assign vld_pipe[0]   = w_issue;
  assign first_pipe[0] = w_first;
  assign last_pipe[0]  = w_last_i;
  assign n_pipe[0]     = r_n;

  for (genvar g = 1; g <= RD_LAT; g++) begin : g_stg
    logic              r_v, r_f, r_l;
    logic [OUT_AW-1:0] r_tn;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v  <= 1'b0;
        r_f  <= 1'b0;
        r_l  <= 1'b0;
        r_tn <= '0;
      end else begin
        r_v  <= vld_pipe[g-1];
        r_f  <= first_pipe[g-1];
        r_l  <= last_pipe[g-1];
        r_tn <= n_pipe[g-1];
      end
    end
    assign vld_pipe[g]   = r_v;
    assign first_pipe[g] = r_f;
    assign last_pipe[g]  = r_l;
    assign n_pipe[g]     = r_tn;
  end

  assign w_sel = vld_pipe[RD_LAT] & first_pipe[RD_LAT];
  assign w_en  = vld_pipe[RD_LAT] & last_pipe[RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_we   <= 1'b0;
      r_out_addr <= '0;
    end else begin
      r_out_we <= w_en;
      if (w_en)                   r_out_addr <= n_pipe[RD_LAT];
      else if (r_state == S_DONE) r_out_addr <= '0;
    end
  end

`ifdef MAC_SEQ_ARGMAX_EN
  logic signed [21:0] r_max;
  logic [OUT_AW-1:0]  r_best, r_cls, w_best_nxt;
  logic               w_take;

  // Neuron 0 seeds the max; strict > keeps the lower index on ties.
  assign w_take     = r_out_we && ((r_out_addr == '0) || (bus.acc_dout > r_max));
  assign w_best_nxt = w_take ? r_out_addr : r_best;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max  <= '0;
      r_best <= '0;
      r_cls  <= '0;
    end else begin
      if (w_take) begin
        r_max  <= bus.acc_dout;
        r_best <= r_out_addr;
      end
      if (r_state == S_IDLE && bus.start)       r_cls <= '0;
      else if (r_state == S_DRAIN && w_final_we) r_cls <= w_best_nxt;
    end
  end

  assign bus.class_id    = r_cls;
  assign bus.class_valid = (r_state == S_DONE);
`else
  logic w_unused_acc;
  assign w_unused_acc    = ^bus.acc_dout;
  assign bus.class_id    = '0;
  assign bus.class_valid = 1'b0;
`endif

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.mem_re   = w_issue;
  assign bus.in_addr  = r_i;
  assign bus.w_addr   = r_w;
  assign bus.b_addr   = r_n;
  assign bus.sel      = w_sel;
  assign bus.en       = w_en;
  assign bus.out_we   = r_out_we;
  assign bus.out_addr = r_out_addr;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench: three sequencers (RD_LAT 0/1/3, N_IN=4, N_OUT=3) driven in lockstep.
module tb_mac_seq_ctrl;

`ifdef MAC_SEQ_ARGMAX_EN
  localparam bit ARG = 1'b1;
`else
  localparam bit ARG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [21:0] sums [0:15];
  int n_chk = 0;
  int n_pass = 0;
  int LAT [3] = '{0, 1, 3};

  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.IN_AW(10), .W_AW(13), .OUT_AW(4)) if0 ();
  mac_seq_ctrl_if #(.IN_AW(10), .W_AW(13), .OUT_AW(4)) if1 ();
  mac_seq_ctrl_if #(.IN_AW(10), .W_AW(13), .OUT_AW(4)) if3 ();

  mac_seq_ctrl #(.N_IN(4), .N_OUT(3), .RD_LAT(0)) u0 (.clk(clk), .rst(rst), .bus(if0.master));
  mac_seq_ctrl #(.N_IN(4), .N_OUT(3), .RD_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(if1.master));
  mac_seq_ctrl #(.N_IN(4), .N_OUT(3), .RD_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(if3.master));

  // The bench plays the accumulator: each DUT sees the sum of the neuron it is writing.
  assign if0.start = start;
  assign if1.start = start;
  assign if3.start = start;
  assign if0.acc_dout = sums[if0.out_addr];
  assign if1.acc_dout = sums[if1.out_addr];
  assign if3.acc_dout = sums[if3.out_addr];

  logic [2:0] busy_v, done_v, re_v, sel_v, en_v, we_v, cv_v;
  logic [2:0][12:0] wa_v;
  logic [2:0][9:0]  ia_v;
  logic [2:0][3:0]  ba_v, oa_v, cid_v;

  assign busy_v = {if3.busy,   if1.busy,   if0.busy};
  assign done_v = {if3.done,   if1.done,   if0.done};
  assign re_v   = {if3.mem_re, if1.mem_re, if0.mem_re};
  assign sel_v  = {if3.sel,    if1.sel,    if0.sel};
  assign en_v   = {if3.en,     if1.en,     if0.en};
  assign we_v   = {if3.out_we, if1.out_we, if0.out_we};
  assign cv_v   = {if3.class_valid, if1.class_valid, if0.class_valid};
  assign wa_v   = {if3.w_addr,   if1.w_addr,   if0.w_addr};
  assign ia_v   = {if3.in_addr,  if1.in_addr,  if0.in_addr};
  assign ba_v   = {if3.b_addr,   if1.b_addr,   if0.b_addr};
  assign oa_v   = {if3.out_addr, if1.out_addr, if0.out_addr};
  assign cid_v  = {if3.class_id, if1.class_id, if0.class_id};

  task automatic chk(input string tag, input int d, input int c,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s lat%0d cyc%0d obs=%0h exp=%0h", tag, LAT[d], c, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_busy"}, d, 0, 32'(busy_v[d]), 0);
      chk({tag, "_done"}, d, 0, 32'(done_v[d]), 0);
      chk({tag, "_re"},   d, 0, 32'(re_v[d]),   0);
      chk({tag, "_sel"},  d, 0, 32'(sel_v[d]),  0);
      chk({tag, "_en"},   d, 0, 32'(en_v[d]),   0);
      chk({tag, "_we"},   d, 0, 32'(we_v[d]),   0);
      chk({tag, "_wa"},   d, 0, 32'(wa_v[d]),   0);
      chk({tag, "_ia"},   d, 0, 32'(ia_v[d]),   0);
      chk({tag, "_ba"},   d, 0, 32'(ba_v[d]),   0);
      chk({tag, "_oa"},   d, 0, 32'(oa_v[d]),   0);
      chk({tag, "_cid"},  d, 0, 32'(cid_v[d]),  0);
      chk({tag, "_cv"},   d, 0, 32'(cv_v[d]),   0);
    end
  endtask

  // One layer from a start pulse (or held start); cycle c counted from the sampling edge.
  task automatic run_layer(input bit hold, input int exp_cls);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      for (int d = 0; d < 3; d++) begin
        int L, dc, idx, ks, ke, kw;
        L   = LAT[d];
        dc  = 14 + L;
        idx = (c <= 12) ? c - 1 : ((c <= dc) ? 11 : 0);
        ks  = c - 1 - L;
        ke  = c - L;
        kw  = c - L - 1;
        if (c <= 15 + L || !hold) begin
          chk("busy", d, c, 32'(busy_v[d]), 32'(c <= dc));
          chk("done", d, c, 32'(done_v[d]), 32'(c == dc));
          chk("mem_re", d, c, 32'(re_v[d]), 32'(c <= 12));
          chk("w_addr", d, c, 32'(wa_v[d]), 32'(idx));
          chk("in_addr", d, c, 32'(ia_v[d]), 32'(idx % 4));
          chk("b_addr", d, c, 32'(ba_v[d]), 32'(idx / 4));
          chk("sel", d, c, 32'(sel_v[d]), 32'(ks == 0 || ks == 4 || ks == 8));
          chk("en", d, c, 32'(en_v[d]), 32'(ke == 4 || ke == 8 || ke == 12));
          chk("out_we", d, c, 32'(we_v[d]), 32'(kw == 4 || kw == 8 || kw == 12));
          if (kw == 4 || kw == 8 || kw == 12)
            chk("out_addr", d, c, 32'(oa_v[d]), 32'(kw / 4 - 1));
          else if (c > dc)
            chk("out_addr_idle", d, c, 32'(oa_v[d]), 0);
          chk("class_valid", d, c, 32'(cv_v[d]), 32'(ARG && c == dc));
          chk("class_id", d, c, 32'(cid_v[d]), 32'((ARG && c >= dc) ? exp_cls : 0));
        end else if (c == 16 + L) begin
          chk("restart_busy", d, c, 32'(busy_v[d]), 1);
          chk("restart_re", d, c, 32'(re_v[d]), 1);
          chk("restart_wa", d, c, 32'(wa_v[d]), 0);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) sums[k] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // All sums equal: ties keep neuron 0.
    run_layer(1'b0, 0);

    sums[0] = -22'sd5; sums[1] = 22'sd300; sums[2] = 22'sd300;
    run_layer(1'b0, 1);

    sums[0] = -22'sd9; sums[1] = -22'sd2; sums[2] = -22'sd7;
    run_layer(1'b0, 1);

    // Held start: the next layer only begins after the IDLE cycle.
    run_layer(1'b1, 1);
    @(negedge clk) start = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    // Asynchronous reset in cycle 7 of a layer.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_busy", 1, 7, 32'(busy_v[1]), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        chk("post_rst_we", d, c, 32'(we_v[d]), 0);
        chk("post_rst_busy", d, c, 32'(busy_v[d]), 0);
      end
    end

    sums[0] = 22'sd7; sums[1] = 22'sd3; sums[2] = 22'sd8;
    run_layer(1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
